sddt_cmd_issuer: RTL and testbench

//  Host-side initiator for the SDDT 128-bit AXIS command stream, in the axi_aclk domain. Replays a host-loaded

---
 rtl/sddt_cmd_issuer_pkg.sv | 18 +
 rtl/sddt_cmd_issuer_if.sv | 15 +
 rtl/sddt_prog_ram.sv | 30 +++
 rtl/sddt_cmd_issuer.sv | 156 +++++++++++++++
 tb/tb_sddt_cmd_issuer.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sddt_cmd_issuer_pkg.sv
// Shared types and default sizes for the SDDT command issuer.
// The FSM encoding lives here so that sddt_core can decode the same values.
package sddt_cmd_issuer_pkg;

  localparam int CMD_WIDTH_DEF  = 128;
  localparam int PROG_DEPTH_DEF = 64;
  localparam int CREDITS_DEF    = 16;
  localparam int LOOP_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } issuer_state_t;

endpackage

// File: rtl/sddt_cmd_issuer_if.sv
// AXI-Stream command channel carrying opaque instruction words into the core's command FIFO.
interface sddt_cmd_issuer_if
  import sddt_cmd_issuer_pkg::*;
#(
  parameter int CMD_WIDTH = CMD_WIDTH_DEF
) ();

  logic [CMD_WIDTH-1:0] tdata;
  logic                 tvalid;
  logic                 tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/sddt_prog_ram.sv
// Simple dual-port program buffer: one write port, one read port with a registered output.
// A read and write to the same address in one cycle returns the old contents.
module sddt_prog_ram #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output register only advances on a fetch, so it doubles as the held command word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sddt_cmd_issuer.sv
// Host-side SDDT command initiator: replays a loaded program N times into the core command stream,
// gating read instructions on credits that mirror free space in the core's read-data FIFO.
module sddt_cmd_issuer
  import sddt_cmd_issuer_pkg::*;
#(
  parameter int CMD_WIDTH  = CMD_WIDTH_DEF,
  parameter int PROG_DEPTH = PROG_DEPTH_DEF,
  parameter int CREDITS    = CREDITS_DEF,
  parameter int LOOP_WIDTH = LOOP_WIDTH_DEF,
  localparam int PA        = $clog2(PROG_DEPTH),
  localparam int CW        = $clog2(CREDITS) + 1
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic                  prog_wr_en,
  input  logic [PA-1:0]         prog_wr_addr,
  input  logic [CMD_WIDTH-1:0]  prog_wr_data,
  input  logic                  prog_wr_is_rd,
  input  logic                  start,
  input  logic                  abort,
  input  logic [PA:0]           prog_len,
  input  logic [LOOP_WIDTH-1:0] loop_count,
  sddt_cmd_issuer_if.master     m_axis_cmd,
  input  logic                  rdata_tvalid,
  input  logic                  rdata_tready,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         credit_avail,
  output logic [31:0]           issued_cnt,
  output logic                  err_credit
);

  localparam logic [CW-1:0] CREDIT_FULL = CW'(CREDITS);

  issuer_state_t         state;
  logic [PA-1:0]         pc;
  logic [PA:0]           len_q;
  logic [LOOP_WIDTH-1:0] loops_q;
  logic                  abort_pend;
  logic [CMD_WIDTH:0]    entry;
  logic                  entry_is_rd;
  logic                  cmd_vld;
  logic                  cmd_hs;
  logic                  take;
  logic                  ret;
  logic                  ret_err;
  logic                  start_acc;
  logic                  pc_last;

  // Take/return arithmetic; a return against a full pool saturates.
  function automatic logic [CW-1:0] credit_step(input logic [CW-1:0] c,
                                                input logic tk, input logic rt);
    case ({tk, rt})
      2'b10:   return c - 1'b1;
      2'b01:   return (c == CREDIT_FULL) ? c : c + 1'b1;
      default: return c;
    endcase
  endfunction

  sddt_prog_ram #(
    .WIDTH (CMD_WIDTH + 1),
    .DEPTH (PROG_DEPTH)
  ) u_prog_ram (
    .clk     (axi_aclk),
    .rst_n   (axi_aresetn),
    .wr_en   (prog_wr_en),
    .wr_addr (prog_wr_addr),
    .wr_data ({prog_wr_is_rd, prog_wr_data}),
    .rd_en   (state == ST_FETCH),
    .rd_addr (pc),
    .rd_data (entry)
  );

  assign entry_is_rd = entry[CMD_WIDTH];

  // Credits only fall on a handshake, so once raised tvalid stays up until accepted.
  assign cmd_vld = (state == ST_ISSUE) && (!entry_is_rd || (credit_avail != '0));
  assign m_axis_cmd.tvalid = cmd_vld;
  assign m_axis_cmd.tdata  = entry[CMD_WIDTH-1:0];

  assign cmd_hs    = cmd_vld && m_axis_cmd.tready;
  assign take      = cmd_hs && entry_is_rd;
  assign ret       = rdata_tvalid && rdata_tready;
  assign ret_err   = ret && !take && (credit_avail == CREDIT_FULL);
  assign start_acc = (state == ST_IDLE) && start && (loop_count != '0) && (prog_len != '0);
  assign pc_last   = ((PA+1)'(pc) == (len_q - 1'b1));

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      credit_avail <= CREDIT_FULL;
      err_credit   <= 1'b0;
    end else begin
      credit_avail <= credit_step(credit_avail, take, ret);
      if (ret_err)        err_credit <= 1'b1;
      else if (start_acc) err_credit <= 1'b0;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state      <= ST_IDLE;
      pc         <= '0;
      len_q      <= '0;
      loops_q    <= '0;
      abort_pend <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      issued_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_acc) begin
            state      <= ST_FETCH;
            len_q      <= prog_len;
            loops_q    <= loop_count;
            pc         <= '0;
            issued_cnt <= '0;
            abort_pend <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ST_FETCH: state <= abort ? ST_DRAIN : ST_ISSUE;
        ST_ISSUE: begin
          if (cmd_hs) begin
            issued_cnt <= issued_cnt + 32'd1;
            if (pc_last) begin
              pc <= '0;
              if (loops_q != '0) loops_q <= loops_q - 1'b1;
            end else begin
              pc <= pc + 1'b1;
            end
            if (abort || abort_pend || (pc_last && (loops_q <= LOOP_WIDTH'(1))))
              state <= ST_DRAIN;
            else
              state <= ST_FETCH;
          end else if (abort) begin
            // A presented beat must still complete; a stalled one can be dropped.
            if (cmd_vld) abort_pend <= 1'b1;
            else         state      <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (credit_avail == CREDIT_FULL) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sddt_cmd_issuer.sv
// Directed and randomized bench for sddt_cmd_issuer against a queue-based beat/credit model.
`timescale 1ns/1ps
module tb_sddt_cmd_issuer;
  import sddt_cmd_issuer_pkg::*;

  localparam int CMD_WIDTH  = 128;
  localparam int PROG_DEPTH = 64;
  localparam int CREDITS    = 16;
  localparam int LOOP_WIDTH = 32;
  localparam int PA         = 6;
  localparam int CW         = 5;

  typedef struct packed {
    logic [CMD_WIDTH-1:0] w;
    logic                 rd;
  } ent_t;

  logic                  axi_aclk = 1'b0;
  logic                  axi_aresetn;
  logic                  prog_wr_en;
  logic [PA-1:0]         prog_wr_addr;
  logic [CMD_WIDTH-1:0]  prog_wr_data;
  logic                  prog_wr_is_rd;
  logic                  start;
  logic                  abort;
  logic [PA:0]           prog_len;
  logic [LOOP_WIDTH-1:0] loop_count;
  logic                  rdata_tvalid;
  logic                  rdata_tready;
  logic                  busy;
  logic                  done;
  logic [CW-1:0]         credit_avail;
  logic [31:0]           issued_cnt;
  logic                  err_credit;

  sddt_cmd_issuer_if #(.CMD_WIDTH(CMD_WIDTH)) cmd_if ();

  sddt_cmd_issuer #(
    .CMD_WIDTH  (CMD_WIDTH),
    .PROG_DEPTH (PROG_DEPTH),
    .CREDITS    (CREDITS),
    .LOOP_WIDTH (LOOP_WIDTH)
  ) dut (
    .axi_aclk      (axi_aclk),
    .axi_aresetn   (axi_aresetn),
    .prog_wr_en    (prog_wr_en),
    .prog_wr_addr  (prog_wr_addr),
    .prog_wr_data  (prog_wr_data),
    .prog_wr_is_rd (prog_wr_is_rd),
    .start         (start),
    .abort         (abort),
    .prog_len      (prog_len),
    .loop_count    (loop_count),
    .m_axis_cmd    (cmd_if),
    .rdata_tvalid  (rdata_tvalid),
    .rdata_tready  (rdata_tready),
    .busy          (busy),
    .done          (done),
    .credit_avail  (credit_avail),
    .issued_cnt    (issued_cnt),
    .err_credit    (err_credit)
  );

  always #5 axi_aclk = ~axi_aclk;

  int n_vec = 0;
  int n_err = 0;

  ent_t        prog [PROG_DEPTH];
  ent_t        exp_q[$];
  int          ret_q[$];
  int          m_credit = CREDITS;
  logic        m_err = 1'b0;
  logic [31:0] m_issued = '0;
  int          m_beats = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  int          ret_dly = 5;
  int          ret_budget = 1 << 30;
  bit          rdy_mode = 1'b0;
  logic        rdy_val = 1'b1;
  logic        prev_v = 1'b0, prev_r = 1'b0, prev_done = 1'b0;
  logic [CMD_WIDTH-1:0] prev_d = '0;
  logic        mon_take, mon_ret;
  ent_t        mon_e;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge axi_aclk) cyc <= cyc + 1;

  // Reference model: expected beat stream and credit pool, updated at the falling edge.
  always @(negedge axi_aclk) begin
    if (!axi_aresetn) begin
      exp_q.delete();
      ret_q.delete();
      m_credit  = CREDITS;
      m_err     = 1'b0;
      m_issued  = '0;
      prev_v    = 1'b0;
      prev_done = 1'b0;
    end else begin
      chk("credit_avail", credit_avail, m_credit);
      chk("err_credit", err_credit, m_err);
      chk("issued_cnt", issued_cnt, m_issued);
      chk("done_width", done & prev_done, 0);
      if (prev_v && !prev_r) begin
        chk("hold_tvalid", cmd_if.tvalid, 1);
        chk("hold_tdata", cmd_if.tdata, prev_d);
      end
      if (done) done_cnt++;
      if (start && loop_count != 0 && prog_len != 0) begin
        m_issued = '0;
        m_err    = 1'b0;
        m_beats  = 0;
        done_cnt = 0;
        exp_q.delete();
        for (int l = 0; l < int'(loop_count); l++)
          for (int i = 0; i < int'(prog_len); i++) exp_q.push_back(prog[i]);
      end
      mon_take = 1'b0;
      if (cmd_if.tvalid && cmd_if.tready) begin
        m_issued++;
        m_beats++;
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("tdata", cmd_if.tdata, mon_e.w);
          mon_take = mon_e.rd;
          if (mon_take) ret_q.push_back(cyc + ret_dly);
        end
      end
      mon_ret = rdata_tvalid && rdata_tready;
      if (mon_take && !mon_ret) begin
        chk("credit_underflow", m_credit > 0, 1);
        m_credit--;
      end else if (mon_ret && !mon_take) begin
        if (m_credit == CREDITS) m_err = 1'b1;
        else m_credit++;
      end
      prev_v    = cmd_if.tvalid;
      prev_r    = cmd_if.tready;
      prev_d    = cmd_if.tdata;
      prev_done = done;
    end
  end

  // Command-side tready and read-data return generator.
  initial begin
    rdata_tvalid  = 1'b0;
    rdata_tready  = 1'b0;
    cmd_if.tready = 1'b0;
    forever begin
      @(posedge axi_aclk);
      #2;
      cmd_if.tready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_val;
      if (axi_aresetn && ret_budget > 0 && ret_q.size() > 0 && ret_q[0] <= cyc) begin
        void'(ret_q.pop_front());
        ret_budget--;
        rdata_tvalid = 1'b1;
        rdata_tready = 1'b1;
      end else begin
        rdata_tvalid = 1'b0;
        rdata_tready = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  function automatic logic [CMD_WIDTH-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic load(input int idx, input logic [CMD_WIDTH-1:0] w, input logic rd);
    prog_wr_en    = 1'b1;
    prog_wr_addr  = idx[PA-1:0];
    prog_wr_data  = w;
    prog_wr_is_rd = rd;
    prog[idx]     = {w, rd};
    tick();
    prog_wr_en    = 1'b0;
  endtask

  task automatic start_pulse(input int len, input int loops);
    prog_len   = (PA+1)'(len);
    loop_count = LOOP_WIDTH'(loops);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    bit ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (done_cnt > 0) begin ok = 1'b1; break; end
    end
    chk("done_seen", ok, 1);
  endtask

  task automatic wait_tvalid(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (cmd_if.tvalid) break;
      tick();
    end
    chk("tvalid_wait", cmd_if.tvalid, 1);
  endtask

  initial begin
    logic [CMD_WIDTH-1:0] held;
    int len, loops;
    axi_aresetn = 1'b0;
    prog_wr_en = 1'b0; prog_wr_addr = '0; prog_wr_data = '0; prog_wr_is_rd = 1'b0;
    start = 1'b0; abort = 1'b0; prog_len = '0; loop_count = '0;
    repeat (3) tick();
    chk("rst_tvalid", cmd_if.tvalid, 0);
    chk("rst_tdata", cmd_if.tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_credit", credit_avail, CREDITS);
    chk("rst_issued", issued_cnt, 0);
    chk("rst_err", err_credit, 0);
    axi_aresetn = 1'b1;
    tick();

    // Write/Read/Write program twice, reads echoed after a fixed delay.
    load(0, 128'h0123_4567_89ab_cdef_0000_0000_0000_0001, 1'b0);
    load(1, 128'hfeed_face_dead_beef_0000_0000_0000_0002, 1'b1);
    load(2, 128'h5555_aaaa_5555_aaaa_0000_0000_0000_0003, 1'b0);
    ret_dly = 5;
    start_pulse(3, 2);
    chk("t1_busy", busy, 1);
    wait_done(200);
    chk("t1_issued", issued_cnt, 6);
    chk("t1_beats", m_beats, 6);
    chk("t1_done_once", done_cnt, 1);
    chk("t1_exp_left", exp_q.size(), 0);
    chk("t1_credit", credit_avail, CREDITS);
    chk("t1_busy_end", busy, 0);

    // Single read entry with no returns: the pool runs dry after CREDITS beats.
    load(0, rand_word(), 1'b1);
    ret_budget = 0;
    start_pulse(1, 20);
    repeat (80) tick();
    chk("t2_beats16", m_beats, 16);
    chk("t2_stall_tvalid", cmd_if.tvalid, 0);
    chk("t2_credit0", credit_avail, 0);
    ret_budget = 4;
    repeat (40) tick();
    chk("t2_beats20", m_beats, 20);
    chk("t2_drain_tvalid", cmd_if.tvalid, 0);
    chk("t2_busy", busy, 1);
    ret_budget = 1 << 30;
    wait_done(200);
    chk("t2_credit_end", credit_avail, CREDITS);

    // Back-pressure for 10 cycles: beat must be held steady.
    load(0, rand_word(), 1'b0);
    rdy_val = 1'b0;
    start_pulse(1, 1);
    wait_tvalid(10);
    held = cmd_if.tdata;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_tvalid_held", cmd_if.tvalid, 1);
      chk("t3_tdata_held", cmd_if.tdata, held);
    end
    chk("t3_no_beat_yet", m_beats, 0);
    rdy_val = 1'b1;
    wait_done(50);
    chk("t3_beats", m_beats, 1);
    chk("t3_issued", issued_cnt, 1);

    // Abort while a beat is presented but not accepted.
    for (int i = 0; i < 4; i++) load(i, rand_word(), 1'b0);
    rdy_val = 1'b0;
    start_pulse(4, 3);
    wait_tvalid(10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (2) tick();
    chk("t4_still_valid", cmd_if.tvalid, 1);
    rdy_val = 1'b1;
    wait_done(50);
    repeat (5) tick();
    chk("t4_beats", m_beats, 1);
    chk("t4_issued", issued_cnt, 1);
    chk("t4_busy", busy, 0);
    chk("t4_tvalid", cmd_if.tvalid, 0);

    // Spurious return against a full pool sets the sticky error.
    ret_q.push_back(0);
    repeat (4) tick();
    chk("t5_err_set", err_credit, 1);
    chk("t5_credit_sat", credit_avail, CREDITS);
    repeat (3) tick();
    chk("t5_err_sticky", err_credit, 1);
    load(0, rand_word(), 1'b0);
    start_pulse(1, 1);
    chk("t5_err_cleared", err_credit, 0);
    wait_done(50);

    // Randomized programs with random back-pressure and return latency.
    for (int r = 0; r < 4; r++) begin
      len   = $urandom_range(1, 8);
      loops = $urandom_range(1, 3);
      for (int i = 0; i < len; i++) load(i, rand_word(), 1'($urandom_range(0, 1)));
      ret_dly  = $urandom_range(1, 8);
      rdy_mode = 1'b1;
      start_pulse(len, loops);
      wait_done(2000);
      rdy_mode = 1'b0;
      chk("rnd_issued", issued_cnt, len * loops);
      chk("rnd_exp_left", exp_q.size(), 0);
      chk("rnd_done_once", done_cnt, 1);
      chk("rnd_credit", credit_avail, CREDITS);
    end

    // Asynchronous reset while a beat is presented, then a zero-loop start.
    load(0, rand_word(), 1'b0);
    load(1, rand_word(), 1'b1);
    rdy_val = 1'b0;
    start_pulse(2, 5);
    wait_tvalid(10);
    @(posedge axi_aclk);
    #2;
    axi_aresetn = 1'b0;
    #1;
    chk("t6_tvalid", cmd_if.tvalid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_credit", credit_avail, CREDITS);
    chk("t6_issued", issued_cnt, 0);
    repeat (2) tick();
    axi_aresetn = 1'b1;
    rdy_val = 1'b1;
    tick();
    start_pulse(1, 0);
    repeat (5) tick();
    chk("t6_zero_loop_busy", busy, 0);
    chk("t6_zero_loop_tvalid", cmd_if.tvalid, 0);
    chk("t6_zero_loop_issued", issued_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
